// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_pkg                                                        |
// | Brief    : Shared dither mode encodings, Bayer matrix and threshold helper  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package video_pkg;

    typedef enum logic [1:0] {
        DITHER_TRUNC    = 2'd0,
        DITHER_SPATIAL  = 2'd1,
        DITHER_TEMPORAL = 2'd2
    } dither_mode_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Indexed by {y, x}: M = {{0,2},{3,1}}
    localparam logic [3:0][1:0] c_bayer = {2'd1, 2'd3, 2'd2, 2'd0};

    // Threshold scaled so the four Bayer levels span one output LSB.
    function automatic int unsigned dither_thresh(
        input int unsigned mode,
        input logic        x0,
        input logic        y0,
        input logic [1:0]  frame,
        input int unsigned d
    );
        logic        x;
        logic        y;
        int unsigned b;
        x = x0;
        y = y0;
        if (mode == 32'(DITHER_TEMPORAL)) begin
            x = x0 ^ frame[0];
            y = y0 ^ frame[1];
        end
        b = 32'(c_bayer[{y, x}]);
        if (mode == 32'(DITHER_TRUNC) || d == 0) begin
            dither_thresh = 0;
        end else begin
            dither_thresh = (b << d) >> 2;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_dither_out_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_dither_out_if                                              |
// | Brief    : Core-side video inputs and DAC-side video outputs                |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface video_dither_out_if #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 3
);
    logic                pix_ce;
    logic [IN_BITS-1:0]  red;
    logic [IN_BITS-1:0]  green;
    logic [IN_BITS-1:0]  blue;
    logic                hsync;
    logic                vsync;
    logic                window;
    logic [OUT_BITS-1:0] vga_r;
    logic [OUT_BITS-1:0] vga_g;
    logic [OUT_BITS-1:0] vga_b;
    logic                vga_hs;
    logic                vga_vs;
    logic                vga_de;

    modport master (
        output pix_ce, red, green, blue, hsync, vsync, window,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
    );

    modport slave (
        input  pix_ce, red, green, blue, hsync, vsync, window,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
    );
endinterface
`default_nettype wire

// File: rtl/dither_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dither_channel                                                   |
// | Brief    : Two-stage add / saturate / blank pipe for one colour channel     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module dither_channel #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_ce_i,
    input  logic [IN_BITS-1:0]  pix_i,
    input  logic [IN_BITS-1:0]  thresh_i,   // already stage-1 aligned
    input  logic                win_i,      // already stage-1 aligned
    output logic [OUT_BITS-1:0] pix_o
);
    localparam int unsigned D = IN_BITS - OUT_BITS;

    logic [IN_BITS-1:0]  pix_q;
    logic [OUT_BITS-1:0] out_q;
    logic [OUT_BITS-1:0] out_d;
    logic [IN_BITS:0]    w_sum;
    logic [OUT_BITS:0]   w_top;

    assign w_sum = {1'b0, pix_q} + {1'b0, thresh_i};
    // Top bit of w_top is the carry out of the add.
    assign w_top = (OUT_BITS + 1)'(w_sum >> D);

    always_comb begin
        out_d = '0;
        if (win_i) begin
            out_d = w_top[OUT_BITS] ? '1 : w_top[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= '0;
            out_q <= '0;
        end else if (pix_ce_i) begin
            pix_q <= pix_i;
            out_q <= out_d;
        end
    end

    assign pix_o = out_q;
endmodule
`default_nettype wire

// File: rtl/video_dither_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_dither_out                                                 |
// | Brief    : Ordered-dither video output stage with blanking, sync polarity   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_dither_out
    import video_pkg::*;
#(
    parameter int unsigned IN_BITS     = 8,
    parameter int unsigned OUT_BITS    = 3,
    parameter int unsigned DITHER_MODE = 1,
    parameter int unsigned HS_ACT_LOW  = 1,
    parameter int unsigned VS_ACT_LOW  = 1
) (
    input  logic               clk,
    input  logic               reset,
    video_dither_out_if.slave  vif
);
    localparam int unsigned D = IN_BITS - OUT_BITS;

    logic               x0_q;
    logic               y0_q;
    logic [1:0]         frame_q;
    logic               hs_prev_q;
    logic               vs_prev_q;
    logic [IN_BITS-1:0] thresh_q;
    sync_t              s1_q;
    sync_t              s2_q;
    logic [IN_BITS-1:0] w_thresh;

    // Threshold uses the phase before this pixel's counter update.
    assign w_thresh = IN_BITS'(dither_thresh(DITHER_MODE, x0_q, y0_q, frame_q, D));

    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q      <= 1'b0;
            y0_q      <= 1'b0;
            frame_q   <= 2'd0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            thresh_q  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
        end else if (vif.pix_ce) begin
            x0_q      <= vif.window ? ~x0_q : 1'b0;
            if (vif.hsync && !hs_prev_q) begin
                y0_q <= ~y0_q;
            end
            if (vif.vsync && !vs_prev_q) begin
                frame_q <= frame_q + 2'd1;
            end
            hs_prev_q <= vif.hsync;
            vs_prev_q <= vif.vsync;
            thresh_q  <= w_thresh;
            s1_q.hs   <= vif.hsync;
            s1_q.vs   <= vif.vsync;
            s1_q.de   <= vif.window;
            s2_q      <= s1_q;
        end
    end

    logic [IN_BITS-1:0]  w_chan_in  [3];
    logic [OUT_BITS-1:0] w_chan_out [3];

    assign w_chan_in[0] = vif.red;
    assign w_chan_in[1] = vif.green;
    assign w_chan_in[2] = vif.blue;

    for (genvar c = 0; c < 3; c++) begin : g_chan
        dither_channel #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .pix_ce_i (vif.pix_ce),
            .pix_i    (w_chan_in[c]),
            .thresh_i (thresh_q),
            .win_i    (s1_q.de),
            .pix_o    (w_chan_out[c])
        );
    end

    assign vif.vga_r  = w_chan_out[0];
    assign vif.vga_g  = w_chan_out[1];
    assign vif.vga_b  = w_chan_out[2];
    assign vif.vga_hs = s2_q.hs ^ (HS_ACT_LOW != 0);
    assign vif.vga_vs = s2_q.vs ^ (VS_ACT_LOW != 0);
    assign vif.vga_de = s2_q.de;
endmodule
`default_nettype wire

// File: tb/tb_video_dither_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_video_dither_out                                              |
// | Brief    : Three DUTs (modes 0/1/2) against a behavioural pixel model       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_video_dither_out;
    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 3;
    localparam int D        = IN_BITS - OUT_BITS;
    localparam int ND       = 3;
    localparam int W        = 3 * OUT_BITS + 3;
    localparam bit [ND-1:0] HS_LOW = 3'b011;
    localparam bit [ND-1:0] VS_LOW = 3'b011;
    localparam int BAY [4] = '{0, 2, 3, 1};   // index y*2 + x

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ce_in = 1'b0, win_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
    logic [IN_BITS-1:0] r_in = '0, g_in = '0, b_in = '0;

    always #5 clk = ~clk;

    video_dither_out_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) vif0 ();
    video_dither_out_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) vif1 ();
    video_dither_out_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) vif2 ();

    assign vif0.pix_ce = ce_in;  assign vif1.pix_ce = ce_in;  assign vif2.pix_ce = ce_in;
    assign vif0.red    = r_in;   assign vif1.red    = r_in;   assign vif2.red    = r_in;
    assign vif0.green  = g_in;   assign vif1.green  = g_in;   assign vif2.green  = g_in;
    assign vif0.blue   = b_in;   assign vif1.blue   = b_in;   assign vif2.blue   = b_in;
    assign vif0.hsync  = hs_in;  assign vif1.hsync  = hs_in;  assign vif2.hsync  = hs_in;
    assign vif0.vsync  = vs_in;  assign vif1.vsync  = vs_in;  assign vif2.vsync  = vs_in;
    assign vif0.window = win_in; assign vif1.window = win_in; assign vif2.window = win_in;

    video_dither_out #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DITHER_MODE(0),
                       .HS_ACT_LOW(1), .VS_ACT_LOW(1))
        u_dut0 (.clk(clk), .reset(reset), .vif(vif0));
    video_dither_out #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DITHER_MODE(1),
                       .HS_ACT_LOW(1), .VS_ACT_LOW(1))
        u_dut1 (.clk(clk), .reset(reset), .vif(vif1));
    video_dither_out #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DITHER_MODE(2),
                       .HS_ACT_LOW(0), .VS_ACT_LOW(0))
        u_dut2 (.clk(clk), .reset(reset), .vif(vif2));

    logic [W-1:0] act [ND];
    assign act[0] = {vif0.vga_r, vif0.vga_g, vif0.vga_b, vif0.vga_hs, vif0.vga_vs, vif0.vga_de};
    assign act[1] = {vif1.vga_r, vif1.vga_g, vif1.vga_b, vif1.vga_hs, vif1.vga_vs, vif1.vga_de};
    assign act[2] = {vif2.vga_r, vif2.vga_g, vif2.vga_b, vif2.vga_hs, vif2.vga_vs, vif2.vga_de};

    // ---------------- behavioural model ----------------
    int  run_len, hs_edges, vs_edges;
    bit  hs_last, vs_last;
    int  pend_r, pend_g, pend_b;
    bit  pend_win, pend_hs, pend_vs;
    int  pend_th [ND];
    logic [W-1:0] expv [ND];
    bit  check_en = 1'b0;

    function automatic int thresh_for(input int mode, input int xp, input int yp, input int fr);
        if (mode == 0) return 0;
        if (mode == 2) begin
            xp = xp ^ (fr % 2);
            yp = yp ^ (fr / 2);
        end
        return (BAY[yp * 2 + xp] * (1 << D)) / 4;
    endfunction

    function automatic logic [OUT_BITS-1:0] chan(input int v, input int th, input bit win);
        int s;
        s = v + th;
        if (!win) return '0;
        if (s >= (1 << IN_BITS)) return '1;
        return OUT_BITS'(s / (1 << D));
    endfunction

    task automatic model_reset();
        run_len = 0; hs_edges = 0; vs_edges = 0; hs_last = 0; vs_last = 0;
        pend_r = 0; pend_g = 0; pend_b = 0; pend_win = 0; pend_hs = 0; pend_vs = 0;
        for (int d = 0; d < ND; d++) begin
            pend_th[d] = 0;
            expv[d] = {{(3 * OUT_BITS){1'b0}}, HS_LOW[d], VS_LOW[d], 1'b0};
        end
        check_en = 1'b1;
    endtask

    task automatic model_accept(input bit win, input bit hs, input bit vs,
                                input int r, input int g, input int b);
        for (int d = 0; d < ND; d++) begin
            expv[d] = {chan(pend_r, pend_th[d], pend_win), chan(pend_g, pend_th[d], pend_win),
                       chan(pend_b, pend_th[d], pend_win),
                       pend_hs ^ HS_LOW[d], pend_vs ^ VS_LOW[d], pend_win};
            pend_th[d] = thresh_for(d, run_len % 2, hs_edges % 2, vs_edges % 4);
        end
        pend_r = r; pend_g = g; pend_b = b; pend_win = win; pend_hs = hs; pend_vs = vs;
        run_len = win ? run_len + 1 : 0;
        if (hs && !hs_last) hs_edges++;
        if (vs && !vs_last) vs_edges++;
        hs_last = hs;
        vs_last = vs;
    endtask

    // ---------------- checker ----------------
    typedef struct {
        string name;
        int    d;
        int    field;   // 0 red, 1 hs, 2 vs, 3 de
        int    want;
    } lit_t;
    lit_t lit_q [$];
    int checks = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act[d] !== expv[d]) begin
                    failures++;
                    $display("FAIL outputs_dut%0d t=%0t got=%03h want=%03h", d, $time, act[d], expv[d]);
                end
            end
        end
        while (lit_q.size() > 0) begin
            lit_t l;
            int   got;
            l = lit_q.pop_front();
            case (l.field)
                0:       got = int'(act[l.d][W-1 -: OUT_BITS]);
                1:       got = int'(act[l.d][2]);
                2:       got = int'(act[l.d][1]);
                default: got = int'(act[l.d][0]);
            endcase
            checks++;
            if (got != l.want) begin
                failures++;
                $display("FAIL %s dut%0d got=%0d want=%0d", l.name, l.d, got, l.want);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_lit(input string name, input int d, input int field, input int want);
        lit_t l;
        l.name = name; l.d = d; l.field = field; l.want = want;
        lit_q.push_back(l);
    endtask

    task automatic step(input bit rst_v, input bit ce_v, input bit win_v, input bit hs_v,
                        input bit vs_v, input int r_v, input int g_v, input int b_v);
        reset = rst_v; ce_in = ce_v; win_in = win_v; hs_in = hs_v; vs_in = vs_v;
        r_in = IN_BITS'(r_v); g_in = IN_BITS'(g_v); b_in = IN_BITS'(b_v);
        @(posedge clk);
        if (rst_v) model_reset();
        else if (ce_v) model_accept(win_v, hs_v, vs_v, r_v, g_v, b_v);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input bit win_v, input int r_v);
        step(0, 1, win_v, 0, 0, r_v, r_v, r_v);
    endtask

    initial begin
        int exp_t4 [5];
        exp_t4 = '{0, 1, 1, 0, 0};

        // Truncation, sync polarity
        do_reset();
        step(0, 1, 1, 1, 0, 'hE5, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        expect_lit("trunc_red", 0, 0, 7);
        expect_lit("trunc_hs_low", 0, 1, 0);
        expect_lit("trunc_hs_high", 2, 1, 1);
        expect_lit("trunc_de", 0, 3, 1);

        // Spatial 2x2 pattern over two lines, then saturation at (0,1)
        do_reset();
        pix(1, 'h10);
        pix(1, 'h10);                     expect_lit("bayer_l0p0", 1, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);     expect_lit("bayer_l0p1", 1, 0, 1);
        pix(0, 0);
        pix(1, 'h10);
        pix(1, 'h10);                     expect_lit("bayer_l1p0", 1, 0, 1);
        pix(0, 0);                        expect_lit("bayer_l1p1", 1, 0, 0);
        pix(1, 'hFF);
        pix(0, 0);                        expect_lit("sat_mode1", 1, 0, 7);
        expect_lit("sat_mode0", 0, 0, 7);

        // Temporal rotation over four frames and wrap
        do_reset();
        for (int f = 0; f < 5; f++) begin
            pix(1, 'h10);
            pix(0, 0);
            expect_lit($sformatf("temporal_f%0d", f), 2, 0, exp_t4[f]);
            step(0, 1, 0, 0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0, 0, 0);
        end

        // Window drop mid-line, then fresh x phase
        do_reset();
        pix(1, 'hFF);
        pix(1, 'hFF);                     expect_lit("win_p0", 1, 0, 7);
        pix(0, 'hFF);
        pix(0, 'hFF);                     expect_lit("blank_red", 1, 0, 0);
        expect_lit("blank_de", 1, 3, 0);
        pix(1, 'h10);
        pix(0, 0);                        expect_lit("x_restart", 1, 0, 0);

        // Stall then reset mid-frame
        do_reset();
        pix(1, 'hFF);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        expect_lit("stall_hold", 0, 0, 7);
        do_reset();
        expect_lit("rst_red", 0, 0, 0);
        expect_lit("rst_de", 0, 3, 0);
        expect_lit("rst_hs", 0, 1, 1);
        expect_lit("rst_vs", 0, 2, 1);
        pix(1, 'h10);
        pix(0, 0);                        expect_lit("rst_frame0", 2, 0, 0);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit rv, cv, wv, hv, vv;
            int rr, gg, bb;
            rv = ($urandom_range(0, 599) == 0);
            cv = ($urandom_range(0, 3) != 0);
            wv = ($urandom_range(0, 7) != 0);
            hv = ($urandom_range(0, 5) == 0);
            vv = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            gg = int'($urandom_range(0, 255));
            bb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            step(rv, cv, wv, hv, vv, rr, gg, bb);
        end

        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
